md5_search_sched: RTL
=====================

// Module: md5_search_sched
// PURPOSE
//  Sequencer for the brute-force MD5 password search. Generates 8-digit ASCII
//  decimal candidates, issues N_ENG per cycle to N_ENG parallel md5 engines,
//  tracks in-flight validity, compares returned hashes with target_hash, and
//  reports match or exhaustion. Sits between top-level FSM/LCD and md5 array.
// PARAMETERS
//  N_ENG     3   number of md5 engines fed in parallel (1..8)
//  PIPE_LAT  64  fixed md5 latency, att in -> hash/current_att out, cycles
//  DIGITS    8   searched digits (1..8); upper 8-DIGITS chars held at "0"
// PORTS
//  clk          in   1          clock
//  reset_n      in   1          synchronous, active-low reset
//  start        in   1          1-cycle pulse; begins search from 0
//  abort        in   1          1-cycle pulse; cancels search
//  target_hash  in   128        hash to match; sampled at start
//  att_o        out  64*N_ENG   lane k candidate in [64k +: 64], ASCII, MSD at [63:56]
//  att_vld_o    out  N_ENG      lane k candidate valid this cycle
//  hash_i       in   128*N_ENG  lane k engine hash
//  cand_i       in   64*N_ENG   lane k engine echoed candidate (current_att)
//  busy         out  1          in RUN or DRAIN
//  found        out  1          match found; held in DONE
//  exhausted    out  1          all candidates checked, no match; held in DONE
//  pwd_o        out  64         matching candidate; valid when found
// BEHAVIOUR
//  - Reset: state IDLE; att_o = all "0", att_vld_o=0, busy=found=exhausted=0,
//    pwd_o=0, in-flight valid pipe cleared. Reset mid-search wins over all.
//  - States: IDLE -start-> RUN -last issue-> DRAIN -pipe empty-> DONE;
//    any match in RUN/DRAIN -> DONE(found); abort in RUN/DRAIN/DONE -> IDLE;
//    start in DONE -> RUN (restart); start while busy ignored; abort wins
//    over start/match in the same cycle.
//  - Issue: cycle i of RUN, lane k drives value i*N_ENG+k (decimal), registered.
//    Lane valid only if value <= 10^DIGITS-1; cycle with any lane past max is
//    last issue. Per-lane BCD counters step by N_ENG; no wrap, no rollover.
//  - Validity: att_vld_o delayed PIPE_LAT cycles in shift register; lane k
//    result checked only when delayed valid bit set.
//  - Compare: lane k hit = dvld[k] & (hash_i[k]==target_q). Registered: found
//    and pwd_o <= cand_i[k] one cycle after the hit. Multiple hits same cycle
//    -> lowest k wins. Issuing stops at the hit cycle.
//  - DRAIN: exits when valid pipe is all zero; exhausted=1 if no hit.
//  - DONE: outputs hold until start or abort; abort clears found/exhausted.
//  - Latency: lane match issued at RUN cycle i -> found high at i+PIPE_LAT+1.
// CONFIGURATION
//  MD5_SCHED_PERF_EN defined: adds outputs perf_cycles[31:0] (cycles in
//   RUN+DRAIN) and perf_cands[31:0] (valid candidates issued); cleared at
//   start, frozen in DONE, saturate at all-ones.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package md5_sched_pkg: state encoding (IDLE/RUN/DRAIN/DONE),
//  ASCII_ZERO=8'h30, DIGIT_MAX=8'h39, CAND_W=64, HASH_W=128.
//  Sub-module bcd_ascii_add: adds constant 0..8 to 8-char ASCII decimal,
//  returns sum and carry-out (overflow); one instance per lane.
// TESTING
//  Bench: stub md5 = fixed PIPE_LAT delay, hash = f(att) lookup table.
//  1 target=hash("00000005"), N_ENG=3: lane2 issued RUN cycle 1; found at
//    cycle 1+PIPE_LAT+1, pwd_o="00000005", exhausted=0.
//  2 DIGITS=2, no matching target: 34 issue cycles, last has only lane0
//    ("00000099") valid; exhausted=1 after DRAIN, found=0.
//  3 Stub makes lanes 1 and 2 hit same cycle -> pwd_o = lane1 candidate.
//  4 abort 10 cycles into RUN -> IDLE next cycle, att_vld_o=0, no late found
//    from flushed candidates; new start restarts at "00000000".
//  5 reset_n low mid-DRAIN -> all outputs at reset values next cycle.
//  6 MD5_SCHED_PERF_EN, DIGITS=2 exhausted run: perf_cands=100,
//    perf_cycles=34+PIPE_LAT (+-1 per DRAIN exit definition in bench).

Source files
------------

// File: rtl/md5_search_sched_pkg.sv
// Shared types and helpers for the MD5 search scheduler: state encoding,
// ASCII/width constants, small arithmetic helpers.
package md5_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0]        ASCII_ZERO = 8'h30;
    localparam logic [7:0]        DIGIT_MAX  = 8'h39;
    localparam int                CAND_W     = 64;
    localparam int                HASH_W     = 128;
    localparam logic [CAND_W-1:0] CAND_ZERO  = {8{ASCII_ZERO}};

    // Eight-character ASCII form of a single decimal digit value 0..9.
    function automatic logic [CAND_W-1:0] small_to_ascii(input logic [3:0] v);
        return {{7{ASCII_ZERO}}, ASCII_ZERO + {4'd0, v}};
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return cnt;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/md5_search_sched_if.sv
// Candidate/result bus between the search scheduler (master) and the md5
// engine array (slave); lane k occupies slice k of each vector.
interface md5_search_sched_if
    import md5_sched_pkg::*;
#(
    parameter int N_ENG = 3
);
    logic [CAND_W*N_ENG-1:0] att_o;
    logic [N_ENG-1:0]        att_vld_o;
    logic [HASH_W*N_ENG-1:0] hash_i;
    logic [CAND_W*N_ENG-1:0] cand_i;

    modport master (output att_o, att_vld_o, input hash_i, cand_i);
    modport slave  (input att_o, att_vld_o, output hash_i, cand_i);
endinterface

// File: rtl/md5_search_sched_bcd_ascii_add.sv
// Adds a small constant (0..8) to the low DIGITS characters of an 8-char
// ASCII decimal string; carry reports overflow past the last searched digit.
module bcd_ascii_add
    import md5_sched_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic [CAND_W-1:0] a,
    input  logic [3:0]        addend,
    output logic [CAND_W-1:0] sum,
    output logic              carry
);
    // Ripple decimal add from the least significant character (bits [7:0]).
    always_comb begin
        logic [7:0] inc_v;
        logic [7:0] ch_v;
        sum   = a;
        inc_v = {4'd0, addend};
        ch_v  = 8'd0;
        for (int d = 0; d < DIGITS; d++) begin
            ch_v = a[8*d +: 8] + inc_v;
            if (ch_v > DIGIT_MAX) begin
                sum[8*d +: 8] = ch_v - 8'd10;
                inc_v         = 8'd1;
            end else begin
                sum[8*d +: 8] = ch_v;
                inc_v         = 8'd0;
            end
        end
        carry = inc_v[0];
    end
endmodule

// File: rtl/md5_search_sched.sv
// Brute-force MD5 search sequencer: issues ASCII decimal candidates to N_ENG
// engines, compares results, reports match/exhaustion. Optional counters: MD5_SCHED_PERF_EN.
module md5_search_sched
    import md5_sched_pkg::*;
#(
    parameter int N_ENG    = 3,
    parameter int PIPE_LAT = 64,
    parameter int DIGITS   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [HASH_W-1:0] target_hash,
    md5_search_sched_if.master eng,
    output logic              busy,
    output logic              found,
    output logic              exhausted,
    output logic [CAND_W-1:0] pwd_o
`ifdef MD5_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_cands
`endif
);
    localparam int LANES_W = CAND_W * N_ENG;

    state_t               state_r;
    logic [LANES_W-1:0]   att_r;
    logic [LANES_W-1:0]   att_init_s;
    logic [LANES_W-1:0]   att_next_s;
    logic [N_ENG-1:0]     carry_s;
    logic [N_ENG-1:0]     att_vld_r;
    logic [HASH_W-1:0]    target_r;
    logic [N_ENG-1:0]     vld_pipe_r [PIPE_LAT];
    logic                 busy_r;
    logic                 found_r;
    logic                 exhausted_r;
    logic [CAND_W-1:0]    pwd_r;
    logic                 hit_s;
    logic                 pipe_empty_s;
    logic                 flush_s;
    logic [CAND_W-1:0]    hit_cand_s;

    for (genvar k = 0; k < N_ENG; k++) begin : g_lane
        bcd_ascii_add #(.DIGITS(DIGITS)) u_add (
            .a      (att_r[CAND_W*k +: CAND_W]),
            .addend (4'(N_ENG)),
            .sum    (att_next_s[CAND_W*k +: CAND_W]),
            .carry  (carry_s[k])
        );
        assign att_init_s[CAND_W*k +: CAND_W] = small_to_ascii(4'(k));
    end

    // Lane compare; scanning downwards leaves the lowest hitting lane's candidate.
    always_comb begin
        logic lane_hit_v;
        hit_s      = 1'b0;
        hit_cand_s = '0;
        lane_hit_v = 1'b0;
        for (int k = N_ENG - 1; k >= 0; k--) begin
            lane_hit_v = vld_pipe_r[PIPE_LAT-1][k]
                         && (eng.hash_i[HASH_W*k +: HASH_W] == target_r);
            hit_s      = hit_s | lane_hit_v;
            hit_cand_s = lane_hit_v ? eng.cand_i[CAND_W*k +: CAND_W] : hit_cand_s;
        end
    end

    // Drain completes once no issued candidate is still inside the engines.
    always_comb begin
        logic [N_ENG-1:0] any_v;
        any_v = '0;
        for (int s = 0; s < PIPE_LAT; s++) begin
            any_v = any_v | vld_pipe_r[s];
        end
        pipe_empty_s = (any_v == '0);
    end

    assign flush_s = abort | (start & ~busy_r);

    // Validity delay line matching the engine latency; flushed on abort/start.
    always_ff @(posedge clk) begin
        if (!reset_n || flush_s) begin
            for (int s = 0; s < PIPE_LAT; s++) begin
                vld_pipe_r[s] <= '0;
            end
        end else begin
            vld_pipe_r[0] <= att_vld_r;
            for (int s = 1; s < PIPE_LAT; s++) begin
                vld_pipe_r[s] <= vld_pipe_r[s-1];
            end
        end
    end

    // Search FSM with registered candidate and status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            att_r       <= {N_ENG{CAND_ZERO}};
            att_vld_r   <= '0;
            target_r    <= '0;
            busy_r      <= 1'b0;
            found_r     <= 1'b0;
            exhausted_r <= 1'b0;
            pwd_r       <= '0;
        end else if (abort) begin
            state_r     <= ST_IDLE;
            att_r       <= {N_ENG{CAND_ZERO}};
            att_vld_r   <= '0;
            busy_r      <= 1'b0;
            found_r     <= 1'b0;
            exhausted_r <= 1'b0;
            pwd_r       <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r     <= ST_RUN;
                        target_r    <= target_hash;
                        att_r       <= att_init_s;
                        att_vld_r   <= '1;
                        busy_r      <= 1'b1;
                        found_r     <= 1'b0;
                        exhausted_r <= 1'b0;
                        pwd_r       <= '0;
                    end
                end
                ST_RUN: begin
                    if (hit_s) begin
                        state_r   <= ST_DONE;
                        att_vld_r <= '0;
                        busy_r    <= 1'b0;
                        found_r   <= 1'b1;
                        pwd_r     <= hit_cand_s;
                    end else if (!(&att_vld_r)) begin
                        // Some lane already passed the maximum: that was the last issue.
                        state_r   <= ST_DRAIN;
                        att_vld_r <= '0;
                    end else begin
                        att_r     <= att_next_s;
                        att_vld_r <= ~carry_s;
                    end
                end
                ST_DRAIN: begin
                    if (hit_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        found_r <= 1'b1;
                        pwd_r   <= hit_cand_s;
                    end else if (pipe_empty_s) begin
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        exhausted_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    att_vld_r <= '0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign eng.att_o     = att_r;
    assign eng.att_vld_o = att_vld_r;
    assign busy          = busy_r;
    assign found         = found_r;
    assign exhausted     = exhausted_r;
    assign pwd_o         = pwd_r;

`ifdef MD5_SCHED_PERF_EN
    logic [31:0] perf_cycles_r;
    logic [31:0] perf_cands_r;

    // Run statistics: cleared by an accepted start, frozen outside RUN/DRAIN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_cycles_r <= 32'd0;
            perf_cands_r  <= 32'd0;
        end else if (start && !abort && !busy_r) begin
            perf_cycles_r <= 32'd0;
            perf_cands_r  <= 32'd0;
        end else if (busy_r) begin
            perf_cycles_r <= sat_add32(perf_cycles_r, 32'd1);
            perf_cands_r  <= sat_add32(perf_cands_r, {28'd0, popcount8(8'(att_vld_r))});
        end
    end

    assign perf_cycles = perf_cycles_r;
    assign perf_cands  = perf_cands_r;
`endif

endmodule
